// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave bit engine.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic       ACK_BIT            = 1'b0;
    localparam logic       NACK_BIT           = 1'b1;
    localparam logic [6:0] GENERAL_CALL_ADDR  = 7'h00;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h5B;
    localparam logic [3:0] BYTE_BITS          = 4'd8;

    // Open-drain: a 0 on the bus means pull low, a 1 means release.
    function automatic logic drive_for_bit(input logic b);
        return (b == ACK_BIT);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus previous-value flop; emits level and edge strobes.
module i2c_line_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle bus level so leaving reset produces no false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= line;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/slave_sda_generate.sv
// I2C slave bit engine: START/STOP detect, address match, byte shift, ACK drive.
// Optional macro SLAVE_GENERAL_CALL_EN also accepts general-call writes (7'h00 + W).
//
// state     | meaning
// IDLE      | bus free or not addressed, waiting for START
// ADDR      | shifting 7 address bits + R/W
// ADDR_ACK  | driving the address ACK slot
// WR_DATA   | shifting a byte written by the master
// WR_ACK    | driving the ACK slot after a written byte
// RD_DATA   | presenting a read byte on sda
// RD_ACK    | sampling the master ACK/NACK after a read byte
// WAIT_STOP | not ours or NACKed; released until START/STOP
module slave_sda_generate
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] data_received,
    output logic [7:0] data_sent,
    output logic       data_valid
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (scl),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (sda),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       ack_phase_q, ack_phase_d;
    logic       drive_low_q, drive_low_d;
    logic [7:0] data_sent_q, data_sent_d;
    logic       data_valid_q, data_valid_d;
    logic       start_det, stop_det, addr_hit;

    // An sda edge coinciding with an scl edge is data, not a bus condition.
    assign start_det = sda_fall & scl_level & ~scl_rise;
    assign stop_det  = sda_rise & scl_level & ~scl_rise;

`ifdef SLAVE_GENERAL_CALL_EN
    assign addr_hit = (shift_q[6:0] == SLAVE_ADDR) ||
                      ((shift_q[6:0] == GENERAL_CALL_ADDR) && (sda_level == 1'b0));
`else
    assign addr_hit = (shift_q[6:0] == SLAVE_ADDR);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            shift_q      <= 8'h00;
            rw_q         <= 1'b0;
            ack_phase_q  <= 1'b0;
            drive_low_q  <= 1'b0;
            data_sent_q  <= 8'h00;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            ack_phase_q  <= ack_phase_d;
            drive_low_q  <= drive_low_d;
            data_sent_q  <= data_sent_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        ack_phase_d  = ack_phase_q;
        drive_low_d  = drive_low_q;
        data_sent_d  = data_sent_q;
        data_valid_d = 1'b0;
        if (start_det) begin
            state_d     = ADDR;
            cnt_d       = 4'd0;
            ack_phase_d = 1'b0;
            drive_low_d = 1'b0;
        end else if (stop_det) begin
            state_d     = IDLE;
            ack_phase_d = 1'b0;
            drive_low_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_level};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_d == BYTE_BITS) begin
                        cnt_d = 4'd0;
                        if (addr_hit) begin
                            state_d = ADDR_ACK;
                            rw_d    = sda_level;
                        end else begin
                            state_d     = WAIT_STOP;
                            drive_low_d = 1'b0;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_phase_q) begin
                        drive_low_d = drive_for_bit(ACK_BIT);
                        ack_phase_d = 1'b1;
                    end else begin
                        ack_phase_d = 1'b0;
                        cnt_d       = 4'd0;
                        if (!rw_q) begin
                            state_d     = WR_DATA;
                            drive_low_d = 1'b0;
                        end else begin
                            state_d     = RD_DATA;
                            shift_d     = data_received;
                            drive_low_d = drive_for_bit(data_received[7]);
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_level};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_d == BYTE_BITS) begin
                        cnt_d        = 4'd0;
                        data_sent_d  = shift_d;
                        data_valid_d = 1'b1;
                        state_d      = WR_ACK;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!ack_phase_q) begin
                        drive_low_d = drive_for_bit(ACK_BIT);
                        ack_phase_d = 1'b1;
                    end else begin
                        drive_low_d = 1'b0;
                        ack_phase_d = 1'b0;
                        state_d     = WR_DATA;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == BYTE_BITS) begin
                        cnt_d       = 4'd0;
                        drive_low_d = 1'b0;
                        ack_phase_d = 1'b0;
                        state_d     = RD_ACK;
                    end else begin
                        shift_d     = {shift_q[6:0], 1'b0};
                        drive_low_d = drive_for_bit(shift_q[6]);
                    end
                end
                // Reload on the ACK rise; the MSB goes out on the following fall.
                RD_ACK: begin
                    if (!ack_phase_q && scl_rise) begin
                        if (sda_level == ACK_BIT) begin
                            shift_d     = data_received;
                            ack_phase_d = 1'b1;
                        end else begin
                            state_d     = WAIT_STOP;
                            drive_low_d = 1'b0;
                        end
                    end else if (ack_phase_q && scl_fall) begin
                        state_d     = RD_DATA;
                        cnt_d       = 4'd0;
                        ack_phase_d = 1'b0;
                        drive_low_d = drive_for_bit(shift_q[7]);
                    end
                end
                WAIT_STOP: drive_low_d = 1'b0;
                default: begin
                    state_d     = IDLE;
                    drive_low_d = 1'b0;
                end
            endcase
        end
    end

    // Gating with rst releases the line within the reset cycle itself.
    assign sda        = (drive_low_q && !rst) ? 1'b0 : 1'bz;
    assign data_sent  = data_sent_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_slave_sda_generate.sv
// Directed bench for slave_sda_generate: bus-level master tasks, hand-computed expectations.
module tb_slave_sda_generate;
    import i2c_slave_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] data_received = 8'hA5;
    wire  [7:0] data_sent;
    wire        data_valid;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    slave_sda_generate #(.SLAVE_ADDR(7'h5B)) dut (
        .clk           (clk),
        .rst           (rst),
        .scl           (scl),
        .sda           (sda),
        .data_received (data_received),
        .data_sent     (data_sent),
        .data_valid    (data_valid)
    );

    int n_chk = 0;
    int n_pass = 0;
    int dv_cnt = 0;
    int drv_cnt = 0;

    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_cnt++;
        if (sda === 1'b0 && !m_low) drv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        wait_clk(2); m_low = 1'b0;
        wait_clk(3); scl = 1'b1;
        wait_clk(6); m_low = 1'b1;
        wait_clk(6); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(2); m_low = 1'b1;
        wait_clk(3); scl = 1'b1;
        wait_clk(6); m_low = 1'b0;
        wait_clk(8);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(2); m_low = ~b;
        wait_clk(4); scl = 1'b1;
        wait_clk(6); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(2); m_low = 1'b0;
        wait_clk(4); scl = 1'b1;
        wait_clk(3);
        @(negedge clk);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        wait_clk(3); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] by);
        for (int i = 7; i >= 0; i--) send_bit(by[i]);
    endtask

    task automatic recv_byte(output logic [7:0] by);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            by[i] = b;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [2:0] bits3;
        int         base;

        wait_clk(5);
        @(negedge clk);
        chk("reset sda released", {31'b0, sda}, 32'd1);
        chk("reset data_sent", {24'b0, data_sent}, 32'h00);
        chk("reset data_valid", {31'b0, data_valid}, 32'd0);
        chk("reset state", {29'b0, dut.state_q}, {29'b0, IDLE});
        wait_clk(1); rst = 1'b0;
        wait_clk(5);

        // single write 0xCC
        base = dv_cnt;
        bus_start();
        send_byte(8'hB6); recv_bit(ack); chk("wr addr ack", {31'b0, ack}, 32'd0);
        send_byte(8'hCC); recv_bit(ack); chk("wr data ack", {31'b0, ack}, 32'd0);
        bus_stop();
        chk("wr data_sent", {24'b0, data_sent}, 32'hCC);
        chk("wr dv pulses", dv_cnt - base, 32'd1);

        // wrong address 7'h5A
        base = drv_cnt;
        bus_start();
        send_byte(8'hB4); recv_bit(ack); chk("nomatch addr nack", {31'b0, ack}, 32'd1);
        send_byte(8'h77); recv_bit(ack); chk("nomatch data nack", {31'b0, ack}, 32'd1);
        bus_stop();
        chk("nomatch never driven", drv_cnt - base, 32'd0);
        chk("nomatch data_sent", {24'b0, data_sent}, 32'hCC);
        chk("nomatch idle", {29'b0, dut.state_q}, {29'b0, IDLE});

        // read 0xA5, master ACK, read 0x3C, master NACK
        data_received = 8'hA5;
        bus_start();
        send_byte(8'hB7); recv_bit(ack); chk("rd addr ack", {31'b0, ack}, 32'd0);
        recv_byte(rd); chk("rd byte0", {24'b0, rd}, 32'hA5);
        data_received = 8'h3C;
        send_bit(1'b0);
        recv_byte(rd); chk("rd byte1", {24'b0, rd}, 32'h3C);
        send_bit(1'b1);
        bus_stop();
        @(negedge clk);
        chk("rd released", {31'b0, sda}, 32'd1);
        chk("rd idle", {29'b0, dut.state_q}, {29'b0, IDLE});

        // three-byte write
        base = dv_cnt;
        bus_start();
        send_byte(8'hB6); recv_bit(ack); chk("mw addr ack", {31'b0, ack}, 32'd0);
        send_byte(8'h12); recv_bit(ack); chk("mw ack 12", {31'b0, ack}, 32'd0);
        send_byte(8'h34); recv_bit(ack); chk("mw ack 34", {31'b0, ack}, 32'd0);
        send_byte(8'h56); recv_bit(ack); chk("mw ack 56", {31'b0, ack}, 32'd0);
        bus_stop();
        chk("mw dv pulses", dv_cnt - base, 32'd3);
        chk("mw data_sent", {24'b0, data_sent}, 32'h56);

        // repeated START into a read, then reset mid-byte
        data_received = 8'hA5;
        bus_start();
        send_byte(8'hB6); recv_bit(ack); chk("rs wr ack", {31'b0, ack}, 32'd0);
        bus_start();
        send_byte(8'hB7); recv_bit(ack); chk("rs rd ack", {31'b0, ack}, 32'd0);
        for (int i = 2; i >= 0; i--) begin
            recv_bit(ack);
            bits3[i] = ack;
        end
        chk("rs first bits", {29'b0, bits3}, 32'd5);
        wait_clk(5);
        @(negedge clk);
        chk("rs bit4 driven", {31'b0, sda}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst release", {31'b0, sda}, 32'd1);
        @(negedge clk);
        chk("rst idle", {29'b0, dut.state_q}, {29'b0, IDLE});
        wait_clk(1); rst = 1'b0;
        base = drv_cnt;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        chk("post rst quiet", drv_cnt - base, 32'd0);
        bus_stop();

        // general call
        bus_start();
        send_byte(8'h00); recv_bit(ack);
`ifdef SLAVE_GENERAL_CALL_EN
        chk("gc addr ack", {31'b0, ack}, 32'd0);
        send_byte(8'h06); recv_bit(ack); chk("gc data ack", {31'b0, ack}, 32'd0);
        bus_stop();
        chk("gc data_sent", {24'b0, data_sent}, 32'h06);
`else
        chk("gc addr nack", {31'b0, ack}, 32'd1);
        send_byte(8'h06); recv_bit(ack); chk("gc data nack", {31'b0, ack}, 32'd1);
        bus_stop();
        chk("gc data_sent", {24'b0, data_sent}, 32'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
